// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared requester indices, sizes and CDB message type
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ  = 4;
    localparam int CDB_ROB_SIZE = 8;
    localparam int CDB_IXW      = $clog2(CDB_ROB_SIZE);

    // Requester slot assignment on the bus
    localparam int REQ_ALU  = 0;
    localparam int REQ_MUL  = 1;
    localparam int REQ_DIV  = 2;
    localparam int REQ_LOAD = 3;

    typedef struct packed {
        logic [CDB_IXW-1:0] rob_ix;
        logic [31:0]        value;
        logic [31:0]        dest;
    } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// rtl/cdb_arbiter_rr_priority_picker.sv - one-hot winner pickers (round-robin, and age-based when CDB_ARB_OLDEST_FIRST_EN)

module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;
    int            pos;

    // Scan from ptr upward with wrap; the first requesting slot wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = PW'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`ifdef CDB_ARB_OLDEST_FIRST_EN
module age_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IXW     = 3
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*IXW-1:0] rob_ix,
    input  logic [IXW-1:0]         head,
    output logic [NUM_REQ-1:0]     grant
);

    logic [IXW-1:0] age;
    logic [IXW-1:0] best;
    logic           found;

    // Age is distance from the ROB head with natural wrap; strict less-than keeps ties on the lowest index
    always_comb begin
        grant = '0;
        found = 1'b0;
        best  = '0;
        age   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age = rob_ix[i*IXW +: IXW] - head;
            if (req[i] && (!found || age < best)) begin
                grant    = '0;
                grant[i] = 1'b1;
                best     = age;
                found    = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with per-requester holding slots; CDB_ARB_OLDEST_FIRST_EN selects oldest-first grant
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = CDB_NUM_REQ,
    parameter  int ROB_SIZE = CDB_ROB_SIZE,
    localparam int IXW      = $clog2(ROB_SIZE),
    localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [NUM_REQ*IXW-1:0] req_rob_ix_in,
    input  logic [NUM_REQ*32-1:0]  req_value_in,
    input  logic [NUM_REQ*32-1:0]  req_dest_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    input  logic                   flush_in,
    input  logic [IXW-1:0]         rob_head_in,
    output logic                   cdb_valid_out,
    output logic [IXW-1:0]         cdb_rob_ix_out,
    output logic [31:0]            cdb_value_out,
    output logic [31:0]            cdb_dest_out,
    output logic [NUM_REQ-1:0]     grant_out
);

    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] accept;
    logic               bus_enable;
    cdb_msg_t           slot_q [NUM_REQ];
    cdb_msg_t           win_msg;

    // Nothing is broadcast while flushing or while reset holds the slots
    assign bus_enable    = !flush_in && !rst_in;
    assign grant_out     = pick_grant & {NUM_REQ{bus_enable}};
    assign cdb_valid_out = (|pending_q) && bus_enable;

    // A slot can take new data if empty or being drained this very cycle
    assign req_ready_out = {NUM_REQ{!flush_in}} & (~pending_q | grant_out);
    assign accept        = req_valid_in & req_ready_out;

`ifdef CDB_ARB_OLDEST_FIRST_EN
    logic [NUM_REQ*IXW-1:0] slot_ix_flat;

    // Flatten held ROB indices for the age comparator
    always_comb begin
        slot_ix_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_ix_flat[i*IXW +: IXW] = IXW'(slot_q[i].rob_ix);
        end
    end

    age_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IXW     (IXW)
    ) u_picker (
        .req    (pending_q),
        .rob_ix (slot_ix_flat),
        .head   (rob_head_in),
        .grant  (pick_grant)
    );
`else
    logic [PW-1:0]  rr_ptr_q;
    logic [PW-1:0]  win_ix;
    logic [IXW-1:0] unused_rob_head;

    assign unused_rob_head = rob_head_in;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (pending_q),
        .ptr   (rr_ptr_q),
        .grant (pick_grant)
    );

    // Encode the one-hot winner so the pointer can advance past it
    always_comb begin
        win_ix = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_out[i]) begin
                win_ix = PW'(i);
            end
        end
    end

    // Round-robin pointer moves to the slot after the last winner; flush leaves it alone
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr_q <= '0;
        end else if (!flush_in && (|grant_out)) begin
            rr_ptr_q <= (win_ix == PW'(NUM_REQ - 1)) ? '0 : win_ix + 1'b1;
        end
    end
`endif

    // Pending bits: a same-edge recapture keeps a granted slot occupied
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q <= '0;
        end else if (flush_in) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~grant_out) | accept;
        end
    end

    // Slot payload capture; contents are meaningless while the pending bit is clear
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_q[i].rob_ix <= CDB_IXW'(req_rob_ix_in[i*IXW +: IXW]);
                slot_q[i].value  <= req_value_in[i*32 +: 32];
                slot_q[i].dest   <= req_dest_in[i*32 +: 32];
            end
        end
    end

    // Route the winner's slot to the bus; zero when there is no grant
    always_comb begin
        win_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_out[i]) begin
                win_msg = slot_q[i];
            end
        end
    end

    assign cdb_rob_ix_out = IXW'(win_msg.rob_ix);
    assign cdb_value_out  = win_msg.value;
    assign cdb_dest_out   = win_msg.dest;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int NR  = 4;
    localparam int IXW = 3;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR*IXW-1:0] req_rob_ix_in;
    logic [NR*32-1:0]  req_value_in;
    logic [NR*32-1:0]  req_dest_in;
    logic [NR-1:0]     req_ready_out;
    logic              flush_in;
    logic [IXW-1:0]    rob_head_in;
    logic              cdb_valid_out;
    logic [IXW-1:0]    cdb_rob_ix_out;
    logic [31:0]       cdb_value_out;
    logic [31:0]       cdb_dest_out;
    logic [NR-1:0]     grant_out;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_rob_ix_in (req_rob_ix_in),
        .req_value_in  (req_value_in),
        .req_dest_in   (req_dest_in),
        .req_ready_out (req_ready_out),
        .flush_in      (flush_in),
        .rob_head_in   (rob_head_in),
        .cdb_valid_out (cdb_valid_out),
        .cdb_rob_ix_out(cdb_rob_ix_out),
        .cdb_value_out (cdb_value_out),
        .cdb_dest_out  (cdb_dest_out),
        .grant_out     (grant_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IXW-1:0] ix, input logic [31:0] val, input logic [31:0] dst);
        req_valid_in[i]             = 1'b1;
        req_rob_ix_in[i*IXW +: IXW] = ix;
        req_value_in[i*32 +: 32]    = val;
        req_dest_in[i*32 +: 32]     = dst;
    endtask

    task automatic clr_req();
        req_valid_in = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        flush_in      = 1'b0;
        rob_head_in   = '0;
        req_valid_in  = '0;
        req_rob_ix_in = '0;
        req_value_in  = '0;
        req_dest_in   = '0;
        tick();
        tick();
        rst_in = 1'b0;
        #1;

        // reset / idle
        check("rst_valid", cdb_valid_out, 0);
        check("rst_grant", grant_out, 0);
        check("rst_ready", req_ready_out, 4'b1111);
        check("rst_ix", cdb_rob_ix_out, 0);
        check("rst_value", cdb_value_out, 0);
        check("rst_dest", cdb_dest_out, 0);

        // ALU alone
        set_req(0, 3'd3, 32'd42, 32'd5);
        #1;
        check("alu_ready", req_ready_out[0], 1);
        tick();
        clr_req();
        #1;
        check("alu_valid", cdb_valid_out, 1);
        check("alu_ix", cdb_rob_ix_out, 3);
        check("alu_value", cdb_value_out, 42);
        check("alu_dest", cdb_dest_out, 5);
        check("alu_grant", grant_out, 4'b0001);
        tick();
        check("alu_after_valid", cdb_valid_out, 0);
        check("alu_after_grant", grant_out, 0);

        // all four at once drain in order 0..3
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_req(i, IXW'(i), 32'd100 + 32'(i), 32'd200 + 32'(i));
        end
        tick();
        clr_req();
        #1;
        for (int k = 0; k < NR; k++) begin
            check("all_grant", grant_out, 64'(1 << k));
            check("all_ix", cdb_rob_ix_out, 64'(k));
            check("all_value", cdb_value_out, 64'(100 + k));
            check("all_ready", req_ready_out, 64'((1 << (k + 1)) - 1));
            tick();
        end
        check("all_drained", cdb_valid_out, 0);

        // MUL and LOAD held continuously alternate
        do_reset();
        set_req(1, 3'd1, 32'h11, 32'h21);
        set_req(3, 3'd3, 32'h33, 32'h43);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("alt_grant", grant_out, (k % 2 == 0) ? 64'b0010 : 64'b1000);
            check("alt_value", cdb_value_out, (k % 2 == 0) ? 64'h11 : 64'h33);
            check("alt_ready", req_ready_out, (k % 2 == 0) ? 64'b0111 : 64'b1101);
            tick();
        end
        clr_req();

        // flush discards three held results
        do_reset();
        set_req(0, 3'd4, 32'd1, 32'd0);
        set_req(1, 3'd5, 32'd2, 32'd0);
        set_req(2, 3'd6, 32'd3, 32'd0);
        tick();
        clr_req();
        #1;
        check("pre_flush_valid", cdb_valid_out, 1);
        check("pre_flush_grant", grant_out, 4'b0001);
        flush_in = 1'b1;
        set_req(3, 3'd7, 32'd9, 32'd9);
        #1;
        check("flush_valid", cdb_valid_out, 0);
        check("flush_grant", grant_out, 0);
        check("flush_ready", req_ready_out, 0);
        check("flush_ix", cdb_rob_ix_out, 0);
        tick();
        flush_in = 1'b0;
        clr_req();
        #1;
        check("post_flush_valid", cdb_valid_out, 0);
        check("post_flush_grant", grant_out, 0);
        check("post_flush_ready", req_ready_out, 4'b1111);
        set_req(2, 3'd7, 32'd77, 32'd9);
        tick();
        clr_req();
        #1;
        check("resume_valid", cdb_valid_out, 1);
        check("resume_grant", grant_out, 4'b0100);
        check("resume_value", cdb_value_out, 77);
        check("resume_ix", cdb_rob_ix_out, 7);
        tick();
        check("resume_done", cdb_valid_out, 0);

        // reset in the middle of operation
        set_req(1, 3'd2, 32'd55, 32'd1);
        tick();
        clr_req();
        #1;
        check("midrst_pre_valid", cdb_valid_out, 1);
        rst_in = 1'b1;
        #1;
        check("midrst_valid", cdb_valid_out, 0);
        check("midrst_grant", grant_out, 0);
        tick();
        rst_in = 1'b0;
        #1;
        check("midrst_after_valid", cdb_valid_out, 0);
        check("midrst_after_ready", req_ready_out, 4'b1111);

        // ALU rob_ix 1 vs DIV rob_ix 7 with head 6
        do_reset();
        rob_head_in = 3'd6;
        set_req(0, 3'd1, 32'hA1, 32'd0);
        set_req(2, 3'd7, 32'hD7, 32'd0);
        tick();
        clr_req();
        #1;
`ifdef CDB_ARB_OLDEST_FIRST_EN
        check("age_first_grant", grant_out, 4'b0100);
        check("age_first_ix", cdb_rob_ix_out, 7);
        tick();
        check("age_second_grant", grant_out, 4'b0001);
        check("age_second_ix", cdb_rob_ix_out, 1);
`else
        check("head_ign_first_grant", grant_out, 4'b0001);
        check("head_ign_first_ix", cdb_rob_ix_out, 1);
        tick();
        check("head_ign_second_grant", grant_out, 4'b0100);
        check("head_ign_second_ix", cdb_rob_ix_out, 7);
`endif
        tick();
        check("final_idle", cdb_valid_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional-unit result producers: ALU, MUL, DIV and load buffer.
- Each requester owns a one-entry holding slot; at most one result is broadcast per cycle to the reorder buffer and the reservation stations.
- Default grant policy is round-robin. The optional policy is oldest-first relative to the ROB head.
- On a branch-mispredict flush, all held results are discarded.

Parameters:
- NUM_REQ, 4, number of requesters. Index 0=ALU, 1=MUL, 2=DIV, 3=LOAD.
- ROB_SIZE, 8, reorder-buffer entries, power of two. Local constant IXW = $clog2(ROB_SIZE).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- req_valid_in  input  NUM_REQ  bit i: requester i presents a result
- req_rob_ix_in  input  NUM_REQ*IXW  requester i ROB index in bits [i*IXW +: IXW]
- req_value_in  input  NUM_REQ*32  requester i result value in [i*32 +: 32]
- req_dest_in  input  NUM_REQ*32  requester i dest/address offset in [i*32 +: 32]
- req_ready_out  output  NUM_REQ  bit i: slot i can accept this cycle
- flush_in  input  1  ROB flush; discard all held results
- rob_head_in  input  IXW  current ROB head index (used only with the optional feature)
- cdb_valid_out  output  1  broadcast valid
- cdb_rob_ix_out  output  IXW  broadcast ROB index
- cdb_value_out  output  32  broadcast value
- cdb_dest_out  output  32  broadcast dest
- grant_out  output  NUM_REQ  one-hot winner this cycle; zero when idle

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Priority of events: rst_in > flush_in > normal operation.
- State: pending[NUM_REQ], slot registers {rob_ix, value, dest} per requester, rr_ptr (log2 NUM_REQ bits).
- Reset: pending=0, rr_ptr=0. Consequently cdb_valid_out=0, grant_out=0, and all cdb data outputs=0.
- Accept rule:
  - req_ready_out[i] = !flush_in && (!pending[i] || grant_out[i]).
  - On a clock edge where valid && ready, slot i captures the inputs and pending[i] is set.
  - Requesters must hold valid and data stable until ready.
- Grant (combinational from pending and rr_ptr):
  - Winner is the first pending slot scanning i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - grant_out is one-hot for the winner. cdb_* outputs come from the winner's slot.
  - cdb_valid_out = |pending && !flush_in.
  - cdb_rob_ix_out, cdb_value_out and cdb_dest_out are 0 whenever cdb_valid_out=0.
- On a clock edge with a grant:
  - pending[winner] is cleared, unless the same edge re-captures slot winner, in which case it stays set with the new data.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- Latency: a result captured at edge N is visible on the CDB from edge N until it is granted. Minimum latency is 1 cycle.
- Back-to-back: one requester with continuous valid and no competitors gets its result broadcast every cycle.
- Empty: pending=0 gives cdb_valid_out=0, grant_out=0, rr_ptr unchanged.
- All pending: exactly one grant per cycle. With NUM_REQ full slots and no new input, all slots drain in NUM_REQ cycles.
- flush_in high:
  - grant_out=0 and cdb_valid_out=0 that cycle; nothing is accepted.
  - All pending bits clear at the edge; rr_ptr is unchanged.
  - Normal operation resumes the following cycle.
- Reset asserted mid-operation: every held result is dropped and no broadcast occurs that cycle, since all outputs are derived from pending.

Optional Feature:
- Macro: CDB_ARB_OLDEST_FIRST_EN.
- Defined:
  - The winner is the pending slot with the smallest age, where age = (rob_ix - rob_head_in) mod ROB_SIZE, computed in IXW bits with natural wrap.
  - Ties go to the lowest requester index.
  - rr_ptr is not instantiated.
- Undefined: round-robin as above; rob_head_in is ignored.

Decomposition:
- Shared package (types.svh): requester index constants REQ_ALU=0, REQ_MUL=1, REQ_DIV=2, REQ_LOAD=3, and a cdb_msg_t struct {rob_ix, value, dest}.
- One sub-module, rr_priority_picker (inputs req vector and ptr, output one-hot grant). It is replaced by an age comparator when CDB_ARB_OLDEST_FIRST_EN is defined.

Test Plan:
1. Reset, then idle → cdb_valid_out=0, grant_out=0, req_ready_out=4'b1111.
2. ALU alone: rob_ix=3, value=42, dest=5 valid one cycle → next cycle cdb_valid_out=1, rob_ix=3, value=42, grant_out=4'b0001; following cycle cdb_valid_out=0.
3. All four requesters valid in the same cycle with rob_ix 0,1,2,3 → broadcasts rob_ix 0,1,2,3 on four consecutive cycles. While any slot is waiting, its req_ready_out is 0.
4. MUL and LOAD held continuously → grants alternate 4'b0010, 4'b1000, 4'b0010, ... with no requester starved.
5. Three slots pending, then flush_in pulsed for one cycle → cdb_valid_out=0 that cycle; next cycle pending empty and cdb_valid_out=0; a new request is accepted normally afterwards.
6. With CDB_ARB_OLDEST_FIRST_EN, rob_head_in=6, ALU rob_ix=1, DIV rob_ix=7 → DIV (age 1) is granted before ALU (age 3).
